timer_key_loader: RTL and testbench
===================================

# timer_key_loader

Keypad-side controller for the min:sec countdown timer. Collects up to three decimal digits from a keypad strobe interface, validates them as M:SS, and drives the timer's serial load port (`data`/`loadn`) digit by digit. It then controls the timer's `enable` for start, pause and resume, and reacts to the timer's `zero` flag. It is the initiator of the timer load protocol; the countdown timer is the responder.

## Interface
Parameters:
- `LOAD_CYCLES`, 2: cycles `loadn` is held low per digit (≥1).
- `GAP_CYCLES`, 2: cycles `loadn` is held high after each digit (≥1).

Ports:
- `clock`  in  1  single system clock, rising edge.
- `clrn`  in  1  asynchronous, active-low reset.
- `key`  in  4  key code: 0–9 digit, 0xA START, 0xB STOP, 0xC CLEAR, others ignored.
- `key_valid`  in  1  one-cycle strobe qualifying `key`.
- `zero`  in  1  timer count reached 0:00.
- `data`  out  4  digit presented to the timer load port.
- `loadn`  out  1  active-low load strobe to the timer.
- `enable`  out  1  timer count enable.
- `busy`  out  1  high while serializing digits.
- `digit_cnt`  out  2  digits entered so far, saturates at 3.
- `err`  out  1  one-cycle pulse on a rejected START.
- `done`  out  1  one-cycle pulse when a run ends at zero.

## Operation
- All outputs are registered. Reset values: `data`=0, `loadn`=1, `enable`=0, `busy`=0, `digit_cnt`=0, `err`=0, `done`=0, entry buffer=000, state ENTRY.
- Entry buffer: three nibbles {m, t, s}. A digit shifts in from the right: {m,t,s} <= {t,s,d}. The oldest digit is dropped after three entries. `digit_cnt` increments and saturates at 3.
- States: ENTRY, SETUP, LOW, GAP, RUN, PAUSE.
- ENTRY:
  - Digit: shift into the buffer.
  - CLEAR: buffer=000, `digit_cnt`=0.
  - START with t>5 or buffer=000: `err` pulse, stay in ENTRY, buffer kept.
  - Valid START: go to SETUP with digit index 0.
  - STOP: ignored.
- Serialization order: m, then t, then s. The timer shift-loads, so the first digit sent ends in `mins`.
  - SETUP: 1 cycle; `data`=current digit, `loadn`=1.
  - LOW: `LOAD_CYCLES` cycles; `loadn`=0, `data` held.
  - GAP: `GAP_CYCLES` cycles; `loadn`=1, `data` held. After GAP, go to the next digit's SETUP, or to RUN after the third digit.
  - `busy`=1 in SETUP, LOW and GAP.
- During serialization, digits, START and STOP are ignored. CLEAR aborts: `loadn`=1 on the next edge, buffer cleared, state ENTRY.
- RUN:
  - `enable`=1.
  - STOP: go to PAUSE.
  - CLEAR: go to ENTRY, clear the buffer.
  - `zero`=1: `enable`=0, `done` pulse, buffer cleared, state ENTRY.
  - Digits and START are ignored.
- PAUSE:
  - `enable`=0.
  - START: go to RUN.
  - CLEAR: go to ENTRY, clear the buffer.
  - `zero` is ignored.
- Simultaneous `zero` and STOP/CLEAR in RUN: `zero` wins (`done` pulses, state ENTRY).
- `clrn` asserted at any time, including mid-LOW: all outputs return immediately to reset values (`loadn`=1). A partial load is not resumed.

## Timing
- Let k=0 be the edge that samples a valid START.
  - Per-digit period P = 1+`LOAD_CYCLES`+`GAP_CYCLES`.
  - Digit i (0..2): SETUP in cycle 1+i·P; `loadn` low in cycles 2+i·P through 1+i·P+`LOAD_CYCLES`.
  - `enable` rises in cycle 1+3P. With defaults, P=5, `loadn` falls at cycles 2, 7, 12, and `enable` rises at cycle 16.
- A key takes effect in the cycle after the sampling edge (`digit_cnt`, state, `err`).
- `zero` sampled high in RUN clears `enable` on the next edge, with `done` high for that one cycle.
- `key_valid` is a single-cycle strobe. Consecutive strobes are each processed.

## Structure
- Package `timer_pkg` holds:
  - Key code constants: KEY_START=4'hA, KEY_STOP=4'hB, KEY_CLEAR=4'hC.
  - The state encoding.
  - The default `LOAD_CYCLES`/`GAP_CYCLES`.
- Sub-module `timer_load_serializer`:
  - Takes a 12-bit word and a go pulse, plus an abort input.
  - Produces `data`, `loadn` and `busy`, with a one-cycle finished pulse.
- The top level holds the entry buffer, validation, and the RUN/PAUSE control.

## Test plan
- Keys 2,0,6, START (defaults): `data` shows 2,0,6 in cycles 1, 6, 11; `loadn` low in cycles 2–3, 7–8, 12–13; `enable`=1 from cycle 16; timer then shows 2:06.
- Keys 1,7,0, START: `err` pulses once, `enable` stays 0, `digit_cnt`=3, buffer still 170.
- Keys 9,1,2,3, START: sends 1,2,3 (the 9 is dropped). START with an empty buffer: `err` pulses.
- During RUN: STOP gives `enable`=0 and holds; START gives `enable`=1. Drive `zero`=1 in RUN: `enable` drops next edge, `done` is 1 cycle, `digit_cnt`=0.
- CLEAR during the second digit's LOW: `loadn`=1 next cycle, `busy`=0, state ENTRY, `digit_cnt`=0.
- `clrn` pulsed low mid-LOW: `loadn`=1 and all outputs at reset values while asserted; a fresh entry after release works normally.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared key codes, state encoding and load-timing defaults for the
// keypad-side countdown timer loader.
package timer_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned WORD_W = 3 * NIB_W;

  localparam logic [NIB_W-1:0] KEY_START = 4'hA;
  localparam logic [NIB_W-1:0] KEY_STOP  = 4'hB;
  localparam logic [NIB_W-1:0] KEY_CLEAR = 4'hC;

  localparam int unsigned LOAD_CYCLES_DEF = 2;
  localparam int unsigned GAP_CYCLES_DEF  = 2;

  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_SETUP,
    ST_LOW,
    ST_GAP,
    ST_RUN,
    ST_PAUSE
  } state_e;

  // Digit index 0 is the minutes nibble, sent first.
  function automatic logic [NIB_W-1:0] digit_sel(input logic [WORD_W-1:0] word,
                                                 input logic [1:0]        idx);
    case (idx)
      2'd0:    return word[11:8];
      2'd1:    return word[7:4];
      default: return word[3:0];
    endcase
  endfunction

endpackage

// File: rtl/timer_load_serializer.sv
// Drives the timer's serial load port: SETUP, LOW and GAP phases per digit,
// three digits per word, with abort and a finished pulse in the last GAP cycle.
module timer_load_serializer
  import timer_pkg::*;
#(
  parameter int unsigned LOAD_CYCLES = LOAD_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              clrn,
  input  logic              go_i,
  input  logic              abort_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [NIB_W-1:0]  data_o,
  output logic              loadn_o,
  output logic              busy_o,
  output logic              fin_o
);

  localparam int unsigned CNT_W = 8;

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [NIB_W-1:0]   data_q, data_d;
  logic               loadn_q, loadn_d;
  logic               busy_q, busy_d;
  logic               fin_q, fin_d;

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_ENTRY;
      idx_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
      loadn_q <= 1'b1;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      data_q  <= data_d;
      loadn_q <= loadn_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  // fin is raised so that it is visible during the final GAP cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    data_d  = data_q;
    loadn_d = loadn_q;
    busy_d  = busy_q;
    fin_d   = 1'b0;
    if (abort_i) begin
      state_d = ST_ENTRY;
      loadn_d = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ENTRY: begin
          if (go_i) begin
            word_d  = word_i;
            idx_d   = 2'd0;
            data_d  = digit_sel(word_i, 2'd0);
            loadn_d = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_SETUP;
          end
        end
        ST_SETUP: begin
          state_d = ST_LOW;
          loadn_d = 1'b0;
          cnt_d   = '0;
        end
        ST_LOW: begin
          if (cnt_q == CNT_W'(LOAD_CYCLES - 1)) begin
            state_d = ST_GAP;
            loadn_d = 1'b1;
            cnt_d   = '0;
            fin_d   = (idx_q == 2'd2) && (GAP_CYCLES == 1);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
            if (idx_q == 2'd2) begin
              state_d = ST_ENTRY;
              busy_d  = 1'b0;
            end else begin
              idx_d   = idx_q + 2'd1;
              data_d  = digit_sel(word_q, idx_q + 2'd1);
              state_d = ST_SETUP;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            fin_d = (idx_q == 2'd2) && (cnt_q == CNT_W'(GAP_CYCLES - 2));
          end
        end
        default: state_d = ST_ENTRY;
      endcase
    end
  end

  assign data_o  = data_q;
  assign loadn_o = loadn_q;
  assign busy_o  = busy_q;
  assign fin_o   = fin_q;

endmodule

// File: rtl/timer_key_loader.sv
// Keypad controller: collects M:SS digits, validates them, loads the timer
// through the serializer and handles start/pause/resume/zero.
module timer_key_loader
  import timer_pkg::*;
#(
  parameter int unsigned LOAD_CYCLES = LOAD_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF
) (
  input  logic             clock,
  input  logic             clrn,
  input  logic [NIB_W-1:0] key,
  input  logic             key_valid,
  input  logic             zero,
  output logic [NIB_W-1:0] data,
  output logic             loadn,
  output logic             enable,
  output logic             busy,
  output logic [1:0]       digit_cnt,
  output logic             err,
  output logic             done
);

  // ST_SETUP here means "serializer owns the load port".
  state_e            state_q, state_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [1:0]        digit_cnt_q, digit_cnt_d;
  logic              enable_q, enable_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              go_q, go_d;
  logic              abort_c;
  logic              ser_fin;

  assign abort_c = key_valid && (key == KEY_CLEAR) && (state_q == ST_SETUP);

  timer_load_serializer #(
    .LOAD_CYCLES (LOAD_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES)
  ) u_ser (
    .clock   (clock),
    .clrn    (clrn),
    .go_i    (go_q),
    .abort_i (abort_c),
    .word_i  (buf_q),
    .data_o  (data),
    .loadn_o (loadn),
    .busy_o  (busy),
    .fin_o   (ser_fin)
  );

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_ENTRY;
      buf_q       <= '0;
      digit_cnt_q <= '0;
      enable_q    <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      go_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      digit_cnt_q <= digit_cnt_d;
      enable_q    <= enable_d;
      err_q       <= err_d;
      done_q      <= done_d;
      go_q        <= go_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    digit_cnt_d = digit_cnt_q;
    enable_d    = enable_q;
    err_d       = 1'b0;
    done_d      = 1'b0;
    go_d        = 1'b0;
    case (state_q)
      ST_ENTRY: begin
        if (key_valid) begin
          if (key < 4'd10) begin
            buf_d = {buf_q[7:0], key};
            if (digit_cnt_q != 2'd3) digit_cnt_d = digit_cnt_q + 2'd1;
          end else if (key == KEY_CLEAR) begin
            buf_d       = '0;
            digit_cnt_d = '0;
          end else if (key == KEY_START) begin
            if ((buf_q[7:4] > 4'd5) || (buf_q == '0)) begin
              err_d = 1'b1;
            end else begin
              go_d    = 1'b1;
              state_d = ST_SETUP;
            end
          end
        end
      end
      ST_SETUP: begin
        if (abort_c) begin
          buf_d       = '0;
          digit_cnt_d = '0;
          state_d     = ST_ENTRY;
        end else if (ser_fin) begin
          enable_d = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        // zero has priority over a coincident STOP or CLEAR.
        if (zero) begin
          enable_d    = 1'b0;
          done_d      = 1'b1;
          buf_d       = '0;
          digit_cnt_d = '0;
          state_d     = ST_ENTRY;
        end else if (key_valid && (key == KEY_STOP)) begin
          enable_d = 1'b0;
          state_d  = ST_PAUSE;
        end else if (key_valid && (key == KEY_CLEAR)) begin
          enable_d    = 1'b0;
          buf_d       = '0;
          digit_cnt_d = '0;
          state_d     = ST_ENTRY;
        end
      end
      ST_PAUSE: begin
        if (key_valid && (key == KEY_START)) begin
          enable_d = 1'b1;
          state_d  = ST_RUN;
        end else if (key_valid && (key == KEY_CLEAR)) begin
          buf_d       = '0;
          digit_cnt_d = '0;
          state_d     = ST_ENTRY;
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  assign enable    = enable_q;
  assign digit_cnt = digit_cnt_q;
  assign err       = err_q;
  assign done      = done_q;

endmodule

// File: tb/tb_timer_key_loader.sv
// Directed bench for timer_key_loader with default LOAD/GAP timing.
module tb_timer_key_loader;

  logic       clock = 1'b0;
  logic       clrn;
  logic [3:0] key;
  logic       key_valid;
  logic       zero;
  logic [3:0] data;
  logic       loadn;
  logic       enable;
  logic       busy;
  logic [1:0] digit_cnt;
  logic       err;
  logic       done;

  int checks = 0;
  int errors = 0;

  timer_key_loader dut (
    .clock     (clock),
    .clrn      (clrn),
    .key       (key),
    .key_valid (key_valid),
    .zero      (zero),
    .data      (data),
    .loadn     (loadn),
    .enable    (enable),
    .busy      (busy),
    .digit_cnt (digit_cnt),
    .err       (err),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the sampling edge.
  task automatic press(input logic [3:0] k);
    key       = k;
    key_valid = 1'b1;
    @(negedge clock);
    key_valid = 1'b0;
    key       = 4'h0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, 12'(data), 12'h0);
    chk({tag, "_loadn"}, 12'(loadn), 12'h1);
    chk({tag, "_enable"}, 12'(enable), 12'h0);
    chk({tag, "_busy"}, 12'(busy), 12'h0);
    chk({tag, "_digit_cnt"}, 12'(digit_cnt), 12'h0);
    chk({tag, "_err"}, 12'(err), 12'h0);
    chk({tag, "_done"}, 12'(done), 12'h0);
  endtask

  // Starts at cycle 0 (just after START was sampled); ends at cycle 16.
  task automatic run_load(input string tag, input logic [11:0] w, input bit full);
    logic [11:0] wv;
    wv = w;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clock);
      if (c == 1)  chk({tag, "_d0"}, 12'(data), 12'(wv[11:8]));
      if (c == 6)  chk({tag, "_d1"}, 12'(data), 12'(wv[7:4]));
      if (c == 11) chk({tag, "_d2"}, 12'(data), 12'(wv[3:0]));
      if (full && c < 16) begin
        chk($sformatf("%s_loadn_c%0d", tag, c), 12'(loadn),
            12'((((c - 1) % 5) == 1 || ((c - 1) % 5) == 2) ? 0 : 1));
        chk($sformatf("%s_busy_c%0d", tag, c), 12'(busy), 12'h1);
      end
      if (c == 15) chk({tag, "_enable_c15"}, 12'(enable), 12'h0);
      if (c == 16) begin
        chk({tag, "_enable_c16"}, 12'(enable), 12'h1);
        chk({tag, "_busy_c16"}, 12'(busy), 12'h0);
        chk({tag, "_loadn_c16"}, 12'(loadn), 12'h1);
      end
    end
  endtask

  initial begin
    clrn      = 1'b0;
    key       = 4'h0;
    key_valid = 1'b0;
    zero      = 1'b0;
    cycles(2);
    check_reset_outputs("reset");
    clrn = 1'b1;
    cycles(1);

    // 2:06 load with full timing check
    press(4'd2); press(4'd0); press(4'd6);
    chk("cnt_206", 12'(digit_cnt), 12'h3);
    press(4'hA);
    chk("err_206", 12'(err), 12'h0);
    run_load("ld206", 12'h206, 1'b1);

    // pause, zero ignored while paused, resume, then zero ends the run
    press(4'hB);
    chk("pause_en", 12'(enable), 12'h0);
    zero = 1'b1; cycles(1); zero = 1'b0;
    chk("pause_zero_done", 12'(done), 12'h0);
    cycles(3);
    chk("pause_hold_en", 12'(enable), 12'h0);
    press(4'hA);
    chk("resume_en", 12'(enable), 12'h1);
    cycles(2);
    zero = 1'b1; cycles(1); zero = 1'b0;
    chk("zero_en", 12'(enable), 12'h0);
    chk("zero_done", 12'(done), 12'h1);
    chk("zero_cnt", 12'(digit_cnt), 12'h0);
    cycles(1);
    chk("zero_done_pulse", 12'(done), 12'h0);

    // invalid tens digit
    press(4'd1); press(4'd7); press(4'd0);
    press(4'hA);
    chk("err170", 12'(err), 12'h1);
    chk("err170_en", 12'(enable), 12'h0);
    cycles(1);
    chk("err170_pulse", 12'(err), 12'h0);
    chk("err170_cnt", 12'(digit_cnt), 12'h3);
    chk("err170_buf", dut.buf_q, 12'h170);
    chk("err170_busy", 12'(busy), 12'h0);

    // empty buffer
    press(4'hC);
    chk("clr_cnt", 12'(digit_cnt), 12'h0);
    press(4'hA);
    chk("err_empty", 12'(err), 12'h1);

    // oldest digit dropped
    press(4'd9); press(4'd1); press(4'd2); press(4'd3);
    chk("cnt_sat", 12'(digit_cnt), 12'h3);
    press(4'hA);
    run_load("ld123", 12'h123, 1'b0);
    press(4'hC);
    chk("run_clr_en", 12'(enable), 12'h0);
    chk("run_clr_cnt", 12'(digit_cnt), 12'h0);

    // CLEAR during second digit LOW
    press(4'd4); press(4'd5); press(4'd9);
    press(4'hA);
    cycles(7);
    chk("abort_pre_loadn", 12'(loadn), 12'h0);
    chk("abort_pre_data", 12'(data), 12'h5);
    press(4'hC);
    chk("abort_loadn", 12'(loadn), 12'h1);
    chk("abort_busy", 12'(busy), 12'h0);
    chk("abort_cnt", 12'(digit_cnt), 12'h0);
    cycles(10);
    chk("abort_idle_loadn", 12'(loadn), 12'h1);
    chk("abort_idle_en", 12'(enable), 12'h0);
    chk("abort_idle_busy", 12'(busy), 12'h0);

    // async reset mid-LOW
    press(4'd3); press(4'd0); press(4'd0);
    press(4'hA);
    cycles(2);
    chk("rst_pre_loadn", 12'(loadn), 12'h0);
    clrn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clock);
    chk("midrst_hold_loadn", 12'(loadn), 12'h1);
    clrn = 1'b1;
    cycles(1);

    // fresh entry after reset
    press(4'd0); press(4'd0); press(4'd5);
    press(4'hA);
    chk("err_005", 12'(err), 12'h0);
    run_load("ld005", 12'h005, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
